// File: rtl/conv_result_reader_if.sv
// ---------------------------------------------------------------------------
// conv_result_reader_if
// Groups the host-side GPIO handshake and the result-RAM read port of the
// convolution result reader.
//   master : the reader itself (drives RAM enable/address and the GPIO word)
//   slave  : the environment (host GPIO block plus result RAM)
// Signals:
//   i_start     one-cycle pulse, begin readout at address 0
//   i_n_words   number of results to read (sampled with i_start)
//   i_req       host request level, each rising edge requests one word
//   o_ram_en    result RAM read enable (one-cycle pulse per read)
//   o_ram_addr  result RAM read address
//   i_ram_data  result RAM read data
//   o_gpio_data {ack, done, zeros, last, data} word returned to the host
//   o_busy      high while a read is in flight
// ---------------------------------------------------------------------------
interface conv_result_reader_if #(
  parameter int NB_ADDRESS = 10,
  parameter int RAM_WIDTH  = 13,
  parameter int GPIO_D     = 32
);
  logic                  i_start;
  logic [NB_ADDRESS:0]   i_n_words;
  logic                  i_req;
  logic                  o_ram_en;
  logic [NB_ADDRESS-1:0] o_ram_addr;
  logic [RAM_WIDTH-1:0]  i_ram_data;
  logic [GPIO_D-1:0]     o_gpio_data;
  logic                  o_busy;

  modport master (
    input  i_start, i_n_words, i_req, i_ram_data,
    output o_ram_en, o_ram_addr, o_gpio_data, o_busy
  );

  modport slave (
    output i_start, i_n_words, i_req, i_ram_data,
    input  o_ram_en, o_ram_addr, o_gpio_data, o_busy
  );
endinterface

// File: rtl/conv_result_reader.sv
// ---------------------------------------------------------------------------
// conv_result_reader
// Streams convolution results from the result RAM back to the host over the
// GPIO input word. Each rising edge of the host request bit fetches one word;
// the ack bit of the GPIO word flips when that word is on the bus.
// Ports:
//   i_clock  system clock
//   i_reset  synchronous active-high reset
//   bus      conv_result_reader_if.master (handshake + RAM read port)
// All outputs come straight from registers.
// ---------------------------------------------------------------------------
module conv_result_reader #(
  parameter int NB_ADDRESS  = 10,
  parameter int RAM_WIDTH   = 13,
  parameter int GPIO_D      = 32,
  parameter int RAM_LATENCY = 2   // 1..4
) (
  input  logic                 i_clock,
  input  logic                 i_reset,
  conv_result_reader_if.master bus
);

  localparam int PAD = GPIO_D - RAM_WIDTH - 3;

  typedef enum logic [1:0] {
    S_IDLE,
    S_WAIT_REQ,
    S_READ,
    S_DONE
  } state_t;

  state_t                state_q, state_d;
  logic                  req_q;
  logic [NB_ADDRESS:0]   n_words_q, n_words_d;
  logic [NB_ADDRESS-1:0] ptr_q, ptr_d;
  logic [2:0]            cnt_q, cnt_d;
  logic [RAM_WIDTH-1:0]  data_q, data_d;
  logic                  last_q, last_d;
  logic                  done_q, done_d;
  logic                  ack_q, ack_d;
  logic                  ram_en_q, ram_en_d;
  logic [NB_ADDRESS-1:0] ram_addr_q, ram_addr_d;
  logic                  busy_q, busy_d;

  logic req_rise;
  logic is_last;

  assign req_rise = bus.i_req & ~req_q;
  // Widen ptr by one bit so a full-RAM run (n_words = 2^NB_ADDRESS) compares correctly.
  assign is_last  = ({1'b0, ptr_q} == (n_words_q - (NB_ADDRESS+1)'(1)));

  always_comb begin
    state_d    = state_q;
    n_words_d  = n_words_q;
    ptr_d      = ptr_q;
    cnt_d      = cnt_q;
    data_d     = data_q;
    last_d     = last_q;
    done_d     = done_q;
    ack_d      = ack_q;
    ram_en_d   = 1'b0;
    ram_addr_d = ram_addr_q;

    case (state_q)
      S_IDLE, S_DONE, S_WAIT_REQ: begin
        if (bus.i_start) begin
          // Restart: ack keeps its value so the host's toggle tracking stays valid.
          n_words_d = bus.i_n_words;
          ptr_d     = '0;
          data_d    = '0;
          last_d    = 1'b0;
          if (bus.i_n_words == '0) begin
            done_d  = 1'b1;
            state_d = S_DONE;
          end else begin
            done_d  = 1'b0;
            state_d = S_WAIT_REQ;
          end
        end else if (state_q == S_WAIT_REQ && req_rise) begin
          state_d    = S_READ;
          ram_en_d   = 1'b1;
          ram_addr_d = ptr_q;
          cnt_d      = '0;
        end
      end

      S_READ: begin
        cnt_d = cnt_q + 3'd1;
        // cnt_q counts cycles since the enable was visible; data is valid at RAM_LATENCY.
        if (cnt_q == 3'(RAM_LATENCY)) begin
          data_d = bus.i_ram_data;
          last_d = is_last;
          ack_d  = ~ack_q;
          if (is_last) begin
            done_d  = 1'b1;
            state_d = S_DONE;
          end else begin
            ptr_d   = ptr_q + NB_ADDRESS'(1);
            state_d = S_WAIT_REQ;
          end
        end
      end

      default: state_d = S_IDLE;
    endcase

    busy_d = (state_d == S_READ);
  end

  always_ff @(posedge i_clock) begin
    if (i_reset) begin
      state_q    <= S_IDLE;
      req_q      <= 1'b0;
      n_words_q  <= '0;
      ptr_q      <= '0;
      cnt_q      <= '0;
      data_q     <= '0;
      last_q     <= 1'b0;
      done_q     <= 1'b0;
      ack_q      <= 1'b0;
      ram_en_q   <= 1'b0;
      ram_addr_q <= '0;
      busy_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      req_q      <= bus.i_req;
      n_words_q  <= n_words_d;
      ptr_q      <= ptr_d;
      cnt_q      <= cnt_d;
      data_q     <= data_d;
      last_q     <= last_d;
      done_q     <= done_d;
      ack_q      <= ack_d;
      ram_en_q   <= ram_en_d;
      ram_addr_q <= ram_addr_d;
      busy_q     <= busy_d;
    end
  end

  assign bus.o_ram_en    = ram_en_q;
  assign bus.o_ram_addr  = ram_addr_q;
  assign bus.o_busy      = busy_q;
  assign bus.o_gpio_data = {ack_q, done_q, {PAD{1'b0}}, last_q, data_q};

endmodule

// File: tb/tb_conv_result_reader.sv
module tb_conv_result_reader;

  localparam int L = 2;

  typedef struct {
    logic [31:0] val;
    int          cyc;
  } exp_t;

  logic clk;
  logic srst;
  int   cyc = 0;

  conv_result_reader_if #(.NB_ADDRESS(10), .RAM_WIDTH(13), .GPIO_D(32)) bus ();

  conv_result_reader #(
    .NB_ADDRESS(10), .RAM_WIDTH(13), .GPIO_D(32), .RAM_LATENCY(L)
  ) dut (
    .i_clock(clk),
    .i_reset(srst),
    .bus    (bus.master)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // Result RAM model: RAM[a] = a + 0x100, data valid L cycles after the enable.
  logic [9:0] pipe_a [L];
  logic       pipe_v [L];
  initial for (int i = 0; i < L; i++) pipe_v[i] = 1'b0;
  always @(posedge clk) begin
    pipe_a[0] <= bus.o_ram_addr;
    pipe_v[0] <= bus.o_ram_en;
    for (int i = 1; i < L; i++) begin
      pipe_a[i] <= pipe_a[i-1];
      pipe_v[i] <= pipe_v[i-1];
    end
  end
  assign bus.i_ram_data = pipe_v[L-1] ? 13'(pipe_a[L-1] + 10'h100) : 13'h1EAD;

  int   total  = 0;
  int   passed = 0;
  exp_t en_q[$];
  exp_t gpio_q[$];
  logic [31:0] model_gpio = '0;
  logic        ack_m = 1'b0;
  bit          mon_en = 1'b0;

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got === exp) begin
      passed++;
      $display("ok   %s: got %h", name, got);
    end else begin
      $display("FAIL %s: got %h required %h (cycle %0d)", name, got, exp, cyc);
    end
  endtask

  function automatic logic [31:0] mk(input logic ack, input logic done, input logic last,
                                     input logic [12:0] data);
    return {ack, done, 16'h0, last, data};
  endfunction

  task automatic set_model(input logic [31:0] v, input int at);
    if (v != model_gpio) begin
      gpio_q.push_back('{v, at});
      model_gpio = v;
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic start_run(input int n);
    int s;
    step();
    bus.i_start   = 1'b1;
    bus.i_n_words = 11'(n);
    s = cyc;
    set_model(mk(ack_m, (n == 0), 1'b0, 13'h0), s + 1);
    step();
    bus.i_start = 1'b0;
  endtask

  task automatic req_read(input int addr, input bit last);
    int k;
    step();
    bus.i_req = 1'b1;
    k = cyc;
    en_q.push_back('{32'(addr), k + 1});
    ack_m = ~ack_m;
    set_model(mk(ack_m, last, last, 13'(addr + 256)), k + 2 + L);
    step();
    bus.i_req = 1'b0;
    check("busy_in_read", 32'(bus.o_busy), 32'd1);
    repeat (6) step();
  endtask

  task automatic req_ignored();
    step();
    bus.i_req = 1'b1;
    step();
    bus.i_req = 1'b0;
    repeat (6) step();
  endtask

  // Monitor: every RAM enable and every change of the GPIO word must match the next expectation.
  initial begin
    logic [31:0] prev;
    exp_t e;
    wait (mon_en);
    prev = bus.o_gpio_data;
    forever begin
      @(negedge clk);
      if (bus.o_ram_en) begin
        if (en_q.size() == 0) begin
          check("unexpected_ram_en", {22'h0, bus.o_ram_addr}, 32'hFFFF_FFFF);
        end else begin
          e = en_q.pop_front();
          check("ram_addr", {22'h0, bus.o_ram_addr}, e.val);
          check("ram_en_cycle", 32'(cyc), 32'(e.cyc));
        end
      end
      if (bus.o_gpio_data !== prev) begin
        if (gpio_q.size() == 0) begin
          check("unexpected_gpio", bus.o_gpio_data, prev);
        end else begin
          e = gpio_q.pop_front();
          check("gpio_word", bus.o_gpio_data, e.val);
          check("gpio_cycle", 32'(cyc), 32'(e.cyc));
        end
        prev = bus.o_gpio_data;
      end
    end
  end

  initial begin
    int k;
    // T1: reset with req and start held high
    srst          = 1'b1;
    bus.i_req     = 1'b1;
    bus.i_start   = 1'b1;
    bus.i_n_words = 11'd5;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_gpio", bus.o_gpio_data, 32'h0);
    check("rst_ram_en", 32'(bus.o_ram_en), 32'd0);
    check("rst_ram_addr", {22'h0, bus.o_ram_addr}, 32'h0);
    check("rst_busy", 32'(bus.o_busy), 32'd0);
    step();
    srst        = 1'b0;
    bus.i_start = 1'b0;
    mon_en      = 1'b1;
    repeat (3) step();
    bus.i_req = 1'b0;
    repeat (3) step();

    // T2: normal run of four words
    start_run(4);
    req_read(0, 1'b0);
    req_read(1, 1'b0);
    req_read(2, 1'b0);
    req_read(3, 1'b1);

    // T3: held request level gives exactly one read; pointer then at 1
    start_run(4);
    step();
    bus.i_req = 1'b1;
    k = cyc;
    en_q.push_back('{32'd0, k + 1});
    ack_m = ~ack_m;
    set_model(mk(ack_m, 1'b0, 1'b0, 13'h100), k + 2 + L);
    repeat (20) step();
    bus.i_req = 1'b0;
    repeat (4) step();
    req_read(1, 1'b0);

    // T4: second edge during READ is dropped
    start_run(4);
    step();
    bus.i_req = 1'b1;
    k = cyc;
    en_q.push_back('{32'd0, k + 1});
    ack_m = ~ack_m;
    set_model(mk(ack_m, 1'b0, 1'b0, 13'h100), k + 2 + L);
    step();
    bus.i_req = 1'b0;
    step();
    bus.i_req = 1'b1;
    step();
    bus.i_req = 1'b0;
    repeat (6) step();
    req_read(1, 1'b0);

    // T5: zero words, then two words, request after done, restart
    start_run(0);
    req_ignored();
    start_run(2);
    req_read(0, 1'b0);
    req_read(1, 1'b1);
    req_ignored();
    start_run(2);
    req_read(0, 1'b0);

    // T6: reset in the cycle after the RAM enable discards the read
    step();
    srst = 1'b1;
    set_model(32'h0, cyc + 1);
    ack_m = 1'b0;
    step();
    srst = 1'b0;
    start_run(3);
    step();
    bus.i_req = 1'b1;
    k = cyc;
    en_q.push_back('{32'd0, k + 1});
    step();
    bus.i_req = 1'b0;
    srst = 1'b1;
    step();
    srst = 1'b0;
    check("mid_reset_busy", 32'(bus.o_busy), 32'd0);
    repeat (8) step();
    check("mid_reset_gpio", bus.o_gpio_data, 32'h0);
    start_run(3);
    req_read(0, 1'b0);
    check("post_reset_ack", 32'(bus.o_gpio_data[31]), 32'd1);

    repeat (10) step();
    check("en_queue_drained", 32'(en_q.size()), 32'd0);
    check("gpio_queue_drained", 32'(gpio_q.size()), 32'd0);
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
